// File: rtl/fetch_stage_pkg.sv
// Constants shared by the fetch stage, control unit and hazard unit:
// special opcodes, the pipeline NOP encoding and the fetch FSM states.
package fetch_stage_pkg;

    localparam logic [5:0]  OPC_HALT  = 6'b010101;
    localparam logic [5:0]  OPC_NOP   = 6'b111110;
    localparam logic [31:0] INSTR_NOP = 32'hF800_0000;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    function automatic logic is_halt(input logic [31:0] instr);
        return instr[31:26] == OPC_HALT;
    endfunction

endpackage

// File: rtl/fetch_imem.sv
// Word-addressed instruction memory: asynchronous read, synchronous write.
// A same-cycle write and read of one word returns the old contents.
module fetch_imem #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // NOTE: no reset on the array; program contents must survive a pipeline
    // reset, and a resettable array would also block RAM inference.
    always_ff @(posedge clk) begin
        if (we) begin
            // NOTE: non-blocking so the combinational read sees the old word
            // for the rest of this cycle.
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, instruction memory and IF/ID register with
// stall, redirect and HALT freeze. Optional single-step gate: FETCH_DEBUG_STEP_EN.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              PC_W       = 32,
    parameter int              IMEM_DEPTH = 256,
    parameter int              IMEM_AW    = 8,
    parameter logic [PC_W-1:0] RESET_PC   = '0
) (
    input  logic               I_IF_CLK,
    input  logic               I_IF_RESET,
    input  logic               I_IF_STALL,
    input  logic               I_IF_REDIRECT,
    input  logic [PC_W-1:0]    I_IF_TARGET,
    input  logic               I_IF_WE,
    input  logic [IMEM_AW-1:0] I_IF_WADDR,
    input  logic [31:0]        I_IF_WDATA,
`ifdef FETCH_DEBUG_STEP_EN
    input  logic               I_IF_STEP,
`endif
    output logic [31:0]        O_IF_INSTR,
    output logic [PC_W-1:0]    O_IF_PC4,
    output logic               O_IF_VALID,
    output logic [PC_W-1:0]    O_IF_PC,
    output logic               O_IF_HALTED,
    output logic [31:0]        O_IF_FETCH_CNT
);

    localparam logic [PC_W-1:0] PC_STEP    = PC_W'(4);
    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

    fetch_state_t state;
    logic [31:0]  fetch_word;
    logic         advance;

    fetch_imem #(
        .DEPTH (IMEM_DEPTH),
        .AW    (IMEM_AW)
    ) u_imem (
        .clk   (I_IF_CLK),
        .we    (I_IF_WE),
        .waddr (I_IF_WADDR),
        .wdata (I_IF_WDATA),
        .raddr (O_IF_PC[IMEM_AW+1:2]),
        .rdata (fetch_word)
    );

`ifdef FETCH_DEBUG_STEP_EN
    // A cleared step bit looks exactly like a stall to the rest of the stage.
    assign advance = ~I_IF_STALL & I_IF_STEP;
`else
    assign advance = ~I_IF_STALL;
`endif

    always_ff @(posedge I_IF_CLK) begin
        if (I_IF_RESET) begin
            state          <= RUN;
            O_IF_PC        <= RESET_PC;
            O_IF_INSTR     <= INSTR_NOP;
            O_IF_PC4       <= '0;
            O_IF_VALID     <= 1'b0;
            O_IF_FETCH_CNT <= '0;
        end else if (I_IF_REDIRECT) begin
            // Redirect also cancels a HALT fetched on the wrong path.
            state      <= RUN;
            O_IF_PC    <= I_IF_TARGET & ALIGN_MASK;
            O_IF_INSTR <= INSTR_NOP;
            O_IF_VALID <= 1'b0;
        end else if (advance) begin
            if (state == RUN) begin
                O_IF_INSTR     <= fetch_word;
                O_IF_PC4       <= O_IF_PC + PC_STEP;
                O_IF_VALID     <= 1'b1;
                O_IF_FETCH_CNT <= O_IF_FETCH_CNT + 32'd1;
                if (is_halt(fetch_word)) begin
                    state <= HALTED;
                end else begin
                    O_IF_PC <= O_IF_PC + PC_STEP;
                end
            end else begin
                O_IF_INSTR <= INSTR_NOP;
                O_IF_VALID <= 1'b0;
            end
        end
    end

    assign O_IF_HALTED = (state == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// stall/redirect/write/reset traffic, all compared against a behavioural model.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst, stall, redirect, we;
    logic [31:0] target, wdata;
    logic [7:0]  waddr;
`ifdef FETCH_DEBUG_STEP_EN
    logic        step = 1'b1;
`endif

    logic [31:0] instr, pc4, pc, fetch_cnt;
    logic        valid, halted;

    int errors = 0;
    int checks = 0;

    // Behavioural model: memory image, PC, IF/ID contents, halted flag, count.
    logic [31:0] m_mem [256];
    logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
    bit          m_valid, m_halted, m_was_rst;

    always #5 clk = ~clk;

    fetch_stage #(
        .PC_W       (32),
        .IMEM_DEPTH (256),
        .IMEM_AW    (8),
        .RESET_PC   (32'h0)
    ) dut (
        .I_IF_CLK       (clk),
        .I_IF_RESET     (rst),
        .I_IF_STALL     (stall),
        .I_IF_REDIRECT  (redirect),
        .I_IF_TARGET    (target),
        .I_IF_WE        (we),
        .I_IF_WADDR     (waddr),
        .I_IF_WDATA     (wdata),
`ifdef FETCH_DEBUG_STEP_EN
        .I_IF_STEP      (step),
`endif
        .O_IF_INSTR     (instr),
        .O_IF_PC4       (pc4),
        .O_IF_VALID     (valid),
        .O_IF_PC        (pc),
        .O_IF_HALTED    (halted),
        .O_IF_FETCH_CNT (fetch_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock of the reference behaviour, using the inputs about to be sampled.
    task automatic model_step();
        logic [31:0] word;
        word = m_mem[m_pc[9:2]];
        m_was_rst = rst;
        if (rst) begin
            m_pc = 32'h0; m_instr = INSTR_NOP; m_pc4 = 32'h0;
            m_valid = 1'b0; m_halted = 1'b0; m_cnt = 32'h0;
        end else if (redirect) begin
            m_pc = {target[31:2], 2'b00};
            m_instr = INSTR_NOP; m_valid = 1'b0; m_halted = 1'b0;
        end else if (!stall) begin
            if (m_halted) begin
                m_instr = INSTR_NOP; m_valid = 1'b0;
            end else begin
                m_instr = word; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
                m_cnt = m_cnt + 32'd1;
                if (word[31:26] == 6'b010101) m_halted = 1'b1;
                else m_pc = m_pc + 32'd4;
            end
        end
        if (we) m_mem[waddr] = wdata;
    endtask

    task automatic cyc(input bit r, input bit s, input bit d, input logic [31:0] t,
                       input bit w, input logic [7:0] wa, input logic [31:0] wd);
        rst = r; stall = s; redirect = d; target = t; we = w; waddr = wa; wdata = wd;
        model_step();
        @(posedge clk);
        #1;
        check("pc", pc, m_pc);
        check("instr", instr, m_instr);
        check("valid", 32'(valid), 32'(m_valid));
        check("halted", 32'(halted), 32'(m_halted));
        check("fetch_cnt", fetch_cnt, m_cnt);
        if (m_valid || m_was_rst) check("pc4", pc4, m_pc4);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 32'h0, 0, 8'h0, 32'h0);
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 32'h0, 0, 8'h0, 32'h0);
    endtask

    task automatic jump(input logic [31:0] t);
        cyc(0, 0, 1, t, 0, 8'h0, 32'h0);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] d;
        d = $urandom;
        if (d[31:26] == OPC_HALT) d[31] = ~d[31];
        return d;
    endfunction

    initial begin
        logic [31:0] prog [4];
        logic [31:0] d;
        prog[0] = 32'h2001_0005; prog[1] = 32'h2002_0003;
        prog[2] = 32'h0022_1820; prog[3] = 32'h5400_0000;

        // Load the whole memory while reset is held; reset must not disturb it.
        for (int i = 0; i < 256; i++) begin
            if (i < 4) d = prog[i];
            else if (i == 5) d = 32'h5400_0000;
            else d = rand_word();
            cyc(1, 0, 0, 32'h0, 1, 8'(i), d);
        end
        do_reset();
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'hF800_0000);
        check("rst_pc4", pc4, 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_cnt", fetch_cnt, 32'h0);

        // Straight-line program ending in HALT.
        for (int i = 0; i < 4; i++) begin
            run(1);
            check("prog_instr", instr, prog[i]);
            check("prog_pc4", pc4, 32'(4 * (i + 1)));
            check("prog_valid", 32'(valid), 32'h1);
        end
        check("halt_flag", 32'(halted), 32'h1);
        run(1);
        check("halt_pc", pc, 32'h0C);
        check("halt_instr", instr, 32'hF800_0000);
        check("halt_valid", 32'(valid), 32'h0);
        check("halt_cnt", fetch_cnt, 32'h4);
        run(3);
        check("halt_hold_pc", pc, 32'h0C);

        // Three stalled cycles at PC=8.
        do_reset();
        run(2);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 32'h0, 0, 8'h0, 32'h0);
        check("stall_pc", pc, 32'h8);
        check("stall_cnt", fetch_cnt, 32'h2);
        check("stall_instr", instr, prog[1]);
        run(1);
        check("unstall_instr", instr, prog[2]);
        check("unstall_pc4", pc4, 32'hC);

        // Redirect wins over a simultaneous stall.
        do_reset();
        run(1);
        cyc(0, 1, 1, 32'h40, 0, 8'h0, 32'h0);
        check("redir_pc", pc, 32'h40);
        check("redir_instr", instr, 32'hF800_0000);
        check("redir_valid", 32'(valid), 32'h0);
        check("redir_cnt", fetch_cnt, 32'h1);
        run(1);
        check("redir_fetch", instr, m_mem[16]);

        // Misaligned target is forced to a word boundary.
        jump(32'h43);
        check("align_pc", pc, 32'h40);

        // HALT at word 5 followed by a redirect to 0.
        jump(32'h14);
        run(1);
        check("shadow_halted", 32'(halted), 32'h1);
        jump(32'h0);
        check("shadow_cleared", 32'(halted), 32'h0);
        check("shadow_pc", pc, 32'h0);
        run(1);
        check("shadow_resume", instr, prog[0]);

        // Address wrap past the top of memory.
        jump(32'h3FC);
        run(1);
        check("wrap_top", instr, m_mem[255]);
        check("wrap_pc", pc, 32'h400);
        run(1);
        check("wrap_word0", instr, prog[0]);

        // Same-cycle write and fetch of one word returns the old data.
        jump(32'h80);
        d = m_mem[32];
        cyc(0, 0, 0, 32'h0, 1, 8'd32, 32'h1357_9BDF);
        check("wr_old", instr, d);
        jump(32'h80);
        run(1);
        check("wr_new", instr, 32'h1357_9BDF);

        // Reset while halted, writing word 0 in the same cycle.
        jump(32'hC);
        run(1);
        check("pre_rst_halted", 32'(halted), 32'h1);
        cyc(1, 0, 0, 32'h0, 1, 8'd0, 32'h1234_5678);
        check("rst2_halted", 32'(halted), 32'h0);
        check("rst2_pc", pc, 32'h0);
        check("rst2_cnt", fetch_cnt, 32'h0);
        check("rst2_valid", 32'(valid), 32'h0);
        run(1);
        check("rst2_fetch", instr, 32'h1234_5678);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit r, s, dr, w;
            logic [31:0] t, wd;
            r  = ($urandom_range(0, 99) < 1);
            s  = ($urandom_range(0, 99) < 25);
            dr = ($urandom_range(0, 99) < 8);
            w  = ($urandom_range(0, 99) < 10);
            t  = 32'($urandom_range(0, 32'h7FF));
            wd = ($urandom_range(0, 99) < 5) ? 32'h5400_0000 : rand_word();
            cyc(r, s, dr, t, w, 8'($urandom_range(0, 255)), wd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
